// File: rtl/accu_stream_if.sv
// Stream bundle for accu_stream: sample input side, group-result output side and flush.
interface accu_stream_if #(
    parameter int DATA_W = 8,
    parameter int NUM    = 4
);
    localparam int OUT_W = DATA_W + $clog2(NUM);
    localparam int CNT_W = $clog2(NUM + 1);

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_in;
    logic              flush;
    logic [OUT_W-1:0]  data_out;
    logic [CNT_W-1:0]  cnt_out;
    logic              valid_out;
    logic              ready_out;

    modport master (
        output data_in, valid_in, flush, ready_out,
        input  ready_in, data_out, cnt_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, flush, ready_out,
        output ready_in, data_out, cnt_out, valid_out
    );
endinterface

// File: rtl/accu_stream.sv
// Streaming group accumulator: sums NUM samples (or fewer on flush) and emits one
// result per group with valid/ready handshakes on both sides.
module accu_stream #(
    parameter int DATA_W = 8,
    parameter int NUM    = 4,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    accu_stream_if.slave  bus
);
    localparam int OUT_W = DATA_W + $clog2(NUM);
    localparam int CNT_W = $clog2(NUM + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             valid_out_q, valid_out_d;

    logic             accept;
    logic             close;
    logic             ext_bit;
    logic [OUT_W-1:0] sample_ext;
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt_sum;

    assign bus.ready_in  = !valid_out_q || bus.ready_out;
    assign bus.data_out  = data_out_q;
    assign bus.cnt_out   = cnt_out_q;
    assign bus.valid_out = valid_out_q;

    assign ext_bit    = (SIGNED != 0) ? bus.data_in[DATA_W-1] : 1'b0;
    assign sample_ext = {{(OUT_W-DATA_W){ext_bit}}, bus.data_in};
    assign accept     = bus.valid_in && bus.ready_in;
    assign sum        = accept ? acc_q + sample_ext : acc_q;
    assign cnt_sum    = cnt_q + CNT_W'(accept);
    // A flush with an empty group and no sample in flight must not emit anything.
    assign close      = (accept && cnt_q == LAST) ||
                        (bus.ready_in && bus.flush && (cnt_q != '0 || accept));

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        cnt_out_d   = cnt_out_q;
        valid_out_d = valid_out_q;
        if (accept) begin
            acc_d = sum;
            cnt_d = cnt_sum;
        end
        if (close) begin
            data_out_d  = sum;
            cnt_out_d   = cnt_sum;
            valid_out_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
        end else if (valid_out_q && bus.ready_out) begin
            valid_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            cnt_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            cnt_out_q   <= cnt_out_d;
            valid_out_q <= valid_out_d;
        end
    end
endmodule

// File: tb/tb_accu_stream.sv
// Directed bench for accu_stream: an unsigned and a signed instance see the same stream.
module tb_accu_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accu_stream_if #(.DATA_W(8), .NUM(4)) uif ();
    accu_stream_if #(.DATA_W(8), .NUM(4)) sif ();

    assign sif.data_in   = uif.data_in;
    assign sif.valid_in  = uif.valid_in;
    assign sif.flush     = uif.flush;
    assign sif.ready_out = uif.ready_out;

    accu_stream #(.DATA_W(8), .NUM(4), .SIGNED(0)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(uif));
    accu_stream #(.DATA_W(8), .NUM(4), .SIGNED(1)) u_sdut (.clk(clk), .rst_n(rst_n), .bus(sif));

    typedef struct {
        logic       vi;
        logic [7:0] d;
        logic       fl;
        logic       ro;
        logic       exp_rdy;
        logic       exp_v;
        logic [9:0] exp_d;
        logic [2:0] exp_c;
        logic       chk_s;
        logic [9:0] exp_sd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vi, input logic [7:0] d, input logic fl, input logic ro,
                       input logic er, input logic ev, input logic [9:0] ed, input logic [2:0] ec,
                       input logic cs = 1'b0, input logic [9:0] esd = '0);
        vec_t v;
        v.vi = vi; v.d = d; v.fl = fl; v.ro = ro;
        v.exp_rdy = er; v.exp_v = ev; v.exp_d = ed; v.exp_c = ec;
        v.chk_s = cs; v.exp_sd = esd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic vi, input logic [7:0] d, input logic fl, input logic ro);
        uif.valid_in  = vi;
        uif.data_in   = d;
        uif.flush     = fl;
        uif.ready_out = ro;
    endtask

    initial begin
        drive(1'b0, 8'd0, 1'b0, 1'b1);

        // 1: continuous 1..8, then a flush-close coinciding with an output transfer
        add(1, 8'd1, 0, 1,  1, 0, 10'd0,  3'd0);
        add(1, 8'd2, 0, 1,  1, 0, 10'd0,  3'd0);
        add(1, 8'd3, 0, 1,  1, 0, 10'd0,  3'd0);
        add(1, 8'd4, 0, 1,  1, 1, 10'd10, 3'd4);
        add(1, 8'd5, 0, 1,  1, 0, 10'd10, 3'd4);
        add(1, 8'd6, 0, 1,  1, 0, 10'd10, 3'd4);
        add(1, 8'd7, 0, 1,  1, 0, 10'd10, 3'd4);
        add(1, 8'd8, 0, 1,  1, 1, 10'd26, 3'd4);
        add(1, 8'd9, 1, 1,  1, 1, 10'd9,  3'd1);
        add(0, 8'd0, 0, 1,  1, 0, 10'd9,  3'd1);
        // 2: max values
        add(1, 8'd255, 0, 1, 1, 0, 10'd9,    3'd1);
        add(1, 8'd255, 0, 1, 1, 0, 10'd9,    3'd1);
        add(1, 8'd255, 0, 1, 1, 0, 10'd9,    3'd1);
        add(1, 8'd255, 0, 1, 1, 1, 10'h3FC,  3'd4);
        add(0, 8'd0,   0, 1, 1, 0, 10'h3FC,  3'd4);
        // 3: backpressure for 3 cycles, sample 5 waits
        add(1, 8'd1, 0, 1,  1, 0, 10'h3FC, 3'd4);
        add(1, 8'd2, 0, 1,  1, 0, 10'h3FC, 3'd4);
        add(1, 8'd3, 0, 1,  1, 0, 10'h3FC, 3'd4);
        add(1, 8'd4, 0, 1,  1, 1, 10'd10,  3'd4);
        add(1, 8'd5, 0, 0,  0, 1, 10'd10,  3'd4);
        add(1, 8'd5, 0, 0,  0, 1, 10'd10,  3'd4);
        add(1, 8'd5, 0, 0,  0, 1, 10'd10,  3'd4);
        add(1, 8'd5, 0, 1,  1, 0, 10'd10,  3'd4);
        add(1, 8'd6, 0, 1,  1, 0, 10'd10,  3'd4);
        add(1, 8'd7, 0, 1,  1, 0, 10'd10,  3'd4);
        add(1, 8'd8, 0, 1,  1, 1, 10'd26,  3'd4);
        add(0, 8'd0, 0, 1,  1, 0, 10'd26,  3'd4);
        // 4: flush alone, flush with a sample, flush on an empty group
        add(1, 8'd5, 0, 1,  1, 0, 10'd26, 3'd4);
        add(1, 8'd6, 0, 1,  1, 0, 10'd26, 3'd4);
        add(0, 8'd0, 1, 1,  1, 1, 10'd11, 3'd2);
        add(1, 8'd3, 0, 1,  1, 0, 10'd11, 3'd2);
        add(1, 8'd7, 1, 1,  1, 1, 10'd10, 3'd2);
        add(0, 8'd0, 1, 1,  1, 0, 10'd10, 3'd2);
        add(0, 8'd0, 1, 1,  1, 0, 10'd10, 3'd2);
        // 5: signed sums (unsigned instance sees 512 in both groups)
        add(1, 8'hFF, 0, 1, 1, 0, 10'd10,  3'd2);
        add(1, 8'h80, 0, 1, 1, 0, 10'd10,  3'd2);
        add(1, 8'h7F, 0, 1, 1, 0, 10'd10,  3'd2);
        add(1, 8'h02, 0, 1, 1, 1, 10'h200, 3'd4, 1, 10'h000);
        add(1, 8'h80, 0, 1, 1, 0, 10'h200, 3'd4);
        add(1, 8'h80, 0, 1, 1, 0, 10'h200, 3'd4);
        add(1, 8'h80, 0, 1, 1, 0, 10'h200, 3'd4);
        add(1, 8'h80, 0, 1, 1, 1, 10'h200, 3'd4, 1, 10'h200);
        add(0, 8'd0,  0, 1, 1, 0, 10'h200, 3'd4, 1, 10'h200);

        // reset state
        #2;
        chk("reset_valid", 32'(uif.valid_out), 32'd0);
        chk("reset_data",  32'(uif.data_out),  32'd0);
        chk("reset_cnt",   32'(uif.cnt_out),   32'd0);
        chk("reset_ready", 32'(uif.ready_in),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].vi, vecs[i].d, vecs[i].fl, vecs[i].ro);
            #1;
            chk($sformatf("ready_in[%0d]", i), 32'(uif.ready_in), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("valid_out[%0d]", i), 32'(uif.valid_out), 32'(vecs[i].exp_v));
            chk($sformatf("data_out[%0d]", i),  32'(uif.data_out),  32'(vecs[i].exp_d));
            chk($sformatf("cnt_out[%0d]", i),   32'(uif.cnt_out),   32'(vecs[i].exp_c));
            if (vecs[i].chk_s)
                chk($sformatf("sdata_out[%0d]", i), 32'(sif.data_out), 32'(vecs[i].exp_sd));
        end

        // 6: reset mid-group discards partial sum; outputs clear asynchronously
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 8'd50, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(uif.valid_out), 32'd0);
        chk("async_rst_data",  32'(uif.data_out),  32'd0);
        chk("async_rst_cnt",   32'(uif.cnt_out),   32'd0);
        chk("async_rst_sdata", 32'(sif.data_out),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 8'd1, 1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(uif.valid_out), 32'd1);
        chk("post_rst_data",  32'(uif.data_out),  32'd4);
        chk("post_rst_cnt",   32'(uif.cnt_out),   32'd4);
        chk("post_rst_sdata", 32'(sif.data_out),  32'd4);
        @(negedge clk);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("post_rst_clear", 32'(uif.valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
